e1of2_sync_tx: RTL

- Clocked transmitter that injects flits from a synchronous processing element into a router leaf input port.
- Encodes binary words onto an e1ofN_M channel with N=2 (dual-rail) and M=WIDTH, and drives it with the four-phase return-to-zero enable handshake.
- Buffers words in a small FIFO and synchronizes the asynchronous enable into the clock domain.
- One instance per leaf input (C1in/C2in side of router2).

---
 rtl/e1of2_pkg.sv | 27 ++
 rtl/e1of2_sync_tx_enable_sync.sv | 18 +
 rtl/e1of2_sync_tx.sv | 85 ++++++++
 3 files changed

// File: rtl/e1of2_pkg.sv
// e1of2_pkg: FSM states, rail indices and dual-rail helpers shared by the e1of2 transmitter
package e1of2_pkg;
  typedef enum logic [1:0] {IDLE, DATA, RTZ} state_t;
  localparam int FALSE_RAIL = 0;
  localparam int TRUE_RAIL = 1;
  localparam int FLIT_W = 9;
  function automatic logic [1:0] encode_bit(input logic b);
    logic [1:0] r;
    r[TRUE_RAIL] = b;
    r[FALSE_RAIL] = ~b;
    return r;
  endfunction
  function automatic logic [2*FLIT_W-1:0] encode_dr(input logic [FLIT_W-1:0] word);
    logic [2*FLIT_W-1:0] r;
    for (int i = 0; i < FLIT_W; i++) r[2*i +: 2] = encode_bit(word[i]);
    return r;
  endfunction
  function automatic logic is_neutral(input logic [2*FLIT_W-1:0] rails);
    return rails == '0;
  endfunction
  function automatic logic is_valid_dr(input logic [2*FLIT_W-1:0] rails);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < FLIT_W; i++) ok = ok & (rails[2*i+TRUE_RAIL] ^ rails[2*i+FALSE_RAIL]);
    return ok;
  endfunction
endpackage

// File: rtl/e1of2_sync_tx_enable_sync.sv
// enable_sync: multi-flop synchronizer bringing the router enable into the clock domain
module enable_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  // Shift the raw enable one stage per clock
  always_comb sync_d = {sync_q[SYNC_STAGES-2:0], d};
  // Chain clears to 0 so the enable reads low until the router's high propagates
  always_ff @(posedge clk or posedge rst)
    if (rst) sync_q <= '0;
    else sync_q <= sync_d;
  assign q = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/e1of2_sync_tx.sv
// e1of2_sync_tx: FIFO-buffered clocked transmitter driving a four-phase dual-rail e1of2 channel
module e1of2_sync_tx
  import e1of2_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [2*WIDTH-1:0]     out_d,
  input  logic                   out_e,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  state_t state_q, state_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [2*WIDTH-1:0] rail_q, rail_d, head_dr;
  logic e_s, push, pop;

  enable_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (.clk(CLK), .rst(RESET), .d(out_e), .q(e_s));

  assign count = wr_ptr_q - rd_ptr_q;
  assign in_ready = count != (AW+1)'(DEPTH);
  assign push = in_valid & in_ready;
  assign busy = (count != '0) | (state_q != IDLE);
  assign out_d = rail_q;

  // FIFO write and pointer advance; extra pointer bit separates full from empty
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q[AW-1:0]] = in_data;
    wr_ptr_d = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
  end

  // Dual-rail image of the FIFO head, exactly one rail high per bit
  always_comb begin
    head_dr = '0;
    for (int i = 0; i < WIDTH; i++) head_dr[2*i +: 2] = encode_bit(mem_q[rd_ptr_q[AW-1:0]][i]);
  end

  // Handshake FSM: present head on enable high, return to neutral on enable low
  always_comb begin
    state_d = state_q;
    rail_d = rail_q;
    pop = 1'b0;
    case (state_q)
      DATA: if (!e_s) begin
        rail_d = '0;
        state_d = RTZ;
      end
      default: if (e_s && count != '0) begin
        rail_d = head_dr;
        pop = 1'b1;
        state_d = DATA;
      end else if (e_s) begin
        rail_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State, pointers, storage and rail register; reset forces the channel neutral at once
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rail_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rail_q <= rail_d;
      mem_q <= mem_d;
    end
endmodule
